axi_address_decoder_ax: RTL and testbench
=========================================

Name: axi_address_decoder_ax

Overview:
- Next-generation address decoder for one slave-side address channel (AR or AW; the mode is a parameter) of the AXI node.
- Decodes the incoming address against per-port, per-region windows and steers valid to exactly one initiator port (lowest index wins on overlap).
- Tracks outstanding transactions internally, with target locking and a depth limit.
- Supports an optional default port; when none is enabled, unmatched requests take a drained error path toward the response allocator.

Parameters:
ADDR_WIDTH, 32, address width
N_INIT_PORT, 8, number of initiator (master-side) ports
N_REGION, 4, address regions per port
MAX_OUTSTANDING, 8, max in-flight transactions before stall (>=1)
CHANNEL_AW, 0, 0 = AR mode, 1 = AW mode (AW: sample_info_o also pulses on normal handshake for W routing)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
valid_i  in  1  address valid from slave port
addr_i  in  ADDR_WIDTH  request address
ready_o  out  1  address ready to slave port
valid_o  out  N_INIT_PORT  one-hot valid to initiator ports
ready_i  in  N_INIT_PORT  ready from initiator ports
start_addr_i  in  N_REGION*N_INIT_PORT*ADDR_WIDTH  region start (inclusive)
end_addr_i  in  N_REGION*N_INIT_PORT*ADDR_WIDTH  region end (inclusive)
enable_region_i  in  N_REGION*N_INIT_PORT  region enables
connectivity_map_i  in  N_INIT_PORT  allowed ports
default_en_i  in  1  route unmatched requests to default_port_i
default_port_i  in  $clog2(N_INIT_PORT)  default port index
trans_done_i  in  1  one pulse per completed transaction (last response beat accepted)
target_o  out  $clog2(N_INIT_PORT)  port of current outstanding group
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight count
error_req_o  out  1  error response request
error_gnt_i  in  1  error response grant
sample_info_o  out  1  pulse: capture ID/len info for response path

Behaviour:
- Reset: state OPERATIVE, cnt=0, target_o=0, hold_port=0; all outputs low (valid_o=0, ready_o=0, error_req_o=0, sample_info_o=0).
- Decode (combinational):
  - hit[r][p] = enable_region_i[r][p] & start <= addr_i <= end.
  - port_hit[p] = |hit[*][p] & connectivity_map_i[p].
  - sel = lowest p with port_hit set.
  - If no port hits: default_en_i ? sel = default_port_i : dec_err = 1.
- Issue permission: allow = (cnt < MAX_OUTSTANDING) & (cnt == 0 | sel == target_o). A different target is blocked until the outstanding count drains, which preserves response ordering.
- State OPERATIVE:
  - valid_i & dec_err: ready_o = 1 and sample_info_o = 1 the same cycle (accept/absorb); next state ERR_DRAIN; valid_o = 0.
  - valid_i & allow: valid_o[sel] = 1, zero-cycle latency; ready_o = ready_i[sel].
    - If ready_i[sel]: handshake.
    - Else: latch hold_port = sel and go to HOLD.
  - valid_i & !allow: valid_o = 0, ready_o = 0 (stall).
- State HOLD:
  - valid_o[hold_port] = 1 regardless of decode or config changes; ready_o = ready_i[hold_port].
  - On handshake return to OPERATIVE. No deassertion of valid_o before handshake (AXI rule).
- Handshake effects: cnt += 1 and target_o <= port.
  - CHANNEL_AW = 1: sample_info_o = 1 on the handshake cycle.
  - CHANNEL_AW = 0: sample_info_o only on the error path.
- State ERR_DRAIN: valid_o = 0, ready_o = 0. When cnt == 0, go to ERR_REQ (cnt == 0 on entry → next cycle ERR_REQ).
- State ERR_REQ: error_req_o = 1 held until error_gnt_i, then OPERATIVE. Grant in the same cycle as the first request is legal. The error transaction is not counted in cnt.
- Counter rules:
  - Simultaneous increment and trans_done_i leaves cnt unchanged.
  - trans_done_i while cnt == 0 is ignored; the sim assertion fires.
  - cnt saturates at MAX_OUTSTANDING by construction (allow gates issue).
  - outstanding_o = cnt.
- Config change mid-transaction affects only new decodes; HOLD and target_o are unaffected.
- Async reset mid-operation returns to reset values immediately. The in-flight count is lost; upstream must reset together.

Decomposition:
- Shared package axi_node_pkg:
  - state enum {OPERATIVE, HOLD, ERR_DRAIN, ERR_REQ}
  - port-index width function
- Sub-module axi_region_match: combinational region compare + connectivity mask + lowest-index priority encode, giving port_hit, sel and no-match flag. It is reusable by the AW and AR instances.
- This module holds the FSM, counter and target lock.

Test Plan:
- Port 2 region 0x1000-0x1FFF; valid addr 0x1800 with ready_i[2] = 1 → valid_o = 0x04 the same cycle, ready_o = 1, outstanding_o = 1, target_o = 2.
- Ports 1 and 3 both match 0x2000 → valid_o = 0x02 only. Ready low for 3 cycles with the map changed mid-hold → valid_o stays 0x02 until handshake.
- MAX_OUTSTANDING = 2: two hits to port 0 then a third → third stalls (ready_o = 0) until trans_done_i, then issues; cnt 2→1→2.
- Outstanding = 1 to port 0, new request to port 4 → stalled until trans_done_i brings cnt to 0, then valid_o = 0x10.
- Unmapped 0xF000, default_en_i = 0, cnt = 2 → ready_o = 1 and sample_info_o = 1 for 1 cycle; error_req_o rises only after 2 trans_done_i pulses; held until error_gnt_i, then OPERATIVE. Same address with default_en_i = 1, default_port_i = 5 → valid_o = 0x20.
- Simultaneous handshake + trans_done_i at cnt = 1 → cnt stays 1. Reset asserted in HOLD → valid_o = 0 and cnt = 0 immediately.

Source files
------------

// File: rtl/axi_node_pkg.sv
// Shared types and helpers for the AXI node address decoders.
package axi_node_pkg;

   // Address decoder control states.
   typedef enum logic [1:0] {
      OPERATIVE = 2'd0,
      HOLD      = 2'd1,
      ERR_DRAIN = 2'd2,
      ERR_REQ   = 2'd3
   } dec_state_e;

   // Width of a port index; a single port still needs one bit.
   function automatic int unsigned port_idx_w(input int unsigned n_ports);
      return (n_ports > 1) ? $clog2(n_ports) : 1;
   endfunction

endpackage

// File: rtl/axi_region_match.sv
// Region compare, connectivity mask and lowest-index priority encode.
// Packed window layout: entry (r, p) sits at flat index r*N_INIT_PORT + p.
module axi_region_match
   import axi_node_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int N_INIT_PORT = 8,
   parameter int N_REGION    = 4
) (
   input  logic [ADDR_WIDTH-1:0]                      addr_i,
   input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] start_addr_i,
   input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] end_addr_i,
   input  logic [N_REGION*N_INIT_PORT-1:0]            enable_region_i,
   input  logic [N_INIT_PORT-1:0]                     connectivity_map_i,
   output logic [N_INIT_PORT-1:0]                     port_hit_o,
   output logic [port_idx_w(N_INIT_PORT)-1:0]         sel_o,
   output logic                                       no_match_o
);

   localparam int PW = port_idx_w(N_INIT_PORT);

   logic [N_INIT_PORT-1:0] region_hit;

   // A port hits when any of its enabled regions contains the address (bounds inclusive).
   always_comb begin
      region_hit = '0;
      for (int p = 0; p < N_INIT_PORT; p++) begin
         for (int r = 0; r < N_REGION; r++) begin
            if (enable_region_i[r*N_INIT_PORT+p] &&
                (addr_i >= start_addr_i[(r*N_INIT_PORT+p)*ADDR_WIDTH +: ADDR_WIDTH]) &&
                (addr_i <= end_addr_i[(r*N_INIT_PORT+p)*ADDR_WIDTH +: ADDR_WIDTH])) begin
               region_hit[p] = 1'b1;
            end
         end
      end
   end

   assign port_hit_o = region_hit & connectivity_map_i;
   assign no_match_o = ~|port_hit_o;

   // Scan from the top down so the lowest hitting index is the last one written.
   always_comb begin
      sel_o = '0;
      for (int p = N_INIT_PORT - 1; p >= 0; p--) begin
         if (port_hit_o[p]) sel_o = PW'(p);
      end
   end

endmodule

// File: rtl/axi_address_decoder_ax.sv
// Address decoder for one slave-side address channel (AR or AW) of the AXI node.
// Steers valid to one initiator port, locks the target while transactions are
// outstanding, and absorbs unmapped requests into an error path.
// Handshake rule: a transfer happens on a rising clk edge where valid and ready
// are both high; once valid_o is raised it stays on the same port until that
// transfer happens.
module axi_address_decoder_ax
   import axi_node_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int N_INIT_PORT     = 8,
   parameter int N_REGION        = 4,
   parameter int MAX_OUTSTANDING = 8,
   parameter bit CHANNEL_AW      = 1'b0
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       valid_i,
   input  logic [ADDR_WIDTH-1:0]                      addr_i,
   output logic                                       ready_o,
   output logic [N_INIT_PORT-1:0]                     valid_o,
   input  logic [N_INIT_PORT-1:0]                     ready_i,
   input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] start_addr_i,
   input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] end_addr_i,
   input  logic [N_REGION*N_INIT_PORT-1:0]            enable_region_i,
   input  logic [N_INIT_PORT-1:0]                     connectivity_map_i,
   input  logic                                       default_en_i,
   input  logic [port_idx_w(N_INIT_PORT)-1:0]         default_port_i,
   input  logic                                       trans_done_i,
   output logic [port_idx_w(N_INIT_PORT)-1:0]         target_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_o,
   output logic                                       error_req_o,
   input  logic                                       error_gnt_i,
   output logic                                       sample_info_o
);

   localparam int PW = port_idx_w(N_INIT_PORT);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   dec_state_e             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [PW-1:0]          target_q, target_d;
   logic [PW-1:0]          hold_port_q, hold_port_d;

   logic [N_INIT_PORT-1:0] port_hit;
   logic [PW-1:0]          match_sel;
   logic                   no_match;
   logic [PW-1:0]          sel;
   logic                   dec_err;
   logic                   allow;
   logic                   issue;
   logic [PW-1:0]          issue_port;
   logic                   retire;

   axi_region_match #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .N_INIT_PORT (N_INIT_PORT),
      .N_REGION    (N_REGION)
   ) u_match (
      .addr_i             (addr_i),
      .start_addr_i       (start_addr_i),
      .end_addr_i         (end_addr_i),
      .enable_region_i    (enable_region_i),
      .connectivity_map_i (connectivity_map_i),
      .port_hit_o         (port_hit),
      .sel_o              (match_sel),
      .no_match_o         (no_match)
   );

   // Unmatched requests go to the default port when enabled, else to the error path.
   assign sel     = no_match ? default_port_i : match_sel;
   assign dec_err = no_match & ~default_en_i;

   // A new target must wait for the outstanding group to drain so responses stay ordered.
   assign allow = (cnt_q < CW'(MAX_OUTSTANDING)) & ((cnt_q == '0) | (sel == target_q));

   // Completions with nothing outstanding are dropped.
   assign retire = trans_done_i & (cnt_q != '0);

   // Next state and outputs; everything is held low while reset is asserted.
   always_comb begin
      state_d       = state_q;
      hold_port_d   = hold_port_q;
      valid_o       = '0;
      ready_o       = 1'b0;
      error_req_o   = 1'b0;
      sample_info_o = 1'b0;
      issue         = 1'b0;
      issue_port    = sel;
      if (rst_n) begin
         case (state_q)
            OPERATIVE: begin
               if (valid_i) begin
                  if (dec_err) begin
                     ready_o       = 1'b1;
                     sample_info_o = 1'b1;
                     state_d       = ERR_DRAIN;
                  end else if (allow) begin
                     valid_o[sel] = 1'b1;
                     ready_o      = ready_i[sel];
                     if (ready_i[sel]) begin
                        issue         = 1'b1;
                        sample_info_o = CHANNEL_AW;
                     end else begin
                        hold_port_d = sel;
                        state_d     = HOLD;
                     end
                  end
               end
            end
            HOLD: begin
               issue_port           = hold_port_q;
               valid_o[hold_port_q] = 1'b1;
               ready_o              = ready_i[hold_port_q];
               if (ready_i[hold_port_q]) begin
                  issue         = 1'b1;
                  sample_info_o = CHANNEL_AW;
                  state_d       = OPERATIVE;
               end
            end
            ERR_DRAIN: begin
               if (cnt_q == '0) state_d = ERR_REQ;
            end
            ERR_REQ: begin
               error_req_o = 1'b1;
               if (error_gnt_i) state_d = OPERATIVE;
            end
            default: state_d = OPERATIVE;
         endcase
      end
   end

   // Outstanding count and target lock follow issues and completions.
   always_comb begin
      cnt_d    = cnt_q;
      target_d = target_q;
      if (issue) target_d = issue_port;
      if (issue && !retire) cnt_d = cnt_q + CW'(1);
      else if (!issue && retire) cnt_d = cnt_q - CW'(1);
   end

   // State, counter, target and hold-port registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= OPERATIVE;
         cnt_q       <= '0;
         target_q    <= '0;
         hold_port_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         target_q    <= target_d;
         hold_port_q <= hold_port_d;
      end
   end

   assign target_o      = target_q;
   assign outstanding_o = cnt_q;

   // A completion must never arrive with nothing outstanding.
   a_no_spurious_done: assert property (@(posedge clk) disable iff (!rst_n)
      trans_done_i |-> (cnt_q != '0));

endmodule

// File: tb/tb_axi_address_decoder_ax.sv
// Directed bench for axi_address_decoder_ax (AW mode, MAX_OUTSTANDING = 2).
module tb_axi_address_decoder_ax;

   localparam int AW = 32;
   localparam int NP = 8;
   localparam int NR = 4;
   localparam int MO = 2;
   localparam int PW = 3;
   localparam int CW = 2;

   logic                  clk;
   logic                  rst_n;
   logic                  valid_i;
   logic [AW-1:0]         addr_i;
   logic                  ready_o;
   logic [NP-1:0]         valid_o;
   logic [NP-1:0]         ready_i;
   logic [NR*NP*AW-1:0]   start_addr_i;
   logic [NR*NP*AW-1:0]   end_addr_i;
   logic [NR*NP-1:0]      enable_region_i;
   logic [NP-1:0]         connectivity_map_i;
   logic                  default_en_i;
   logic [PW-1:0]         default_port_i;
   logic                  trans_done_i;
   logic [PW-1:0]         target_o;
   logic [CW-1:0]         outstanding_o;
   logic                  error_req_o;
   logic                  error_gnt_i;
   logic                  sample_info_o;

   int n_pass;
   int n_total;

   axi_address_decoder_ax #(
      .ADDR_WIDTH      (AW),
      .N_INIT_PORT     (NP),
      .N_REGION        (NR),
      .MAX_OUTSTANDING (MO),
      .CHANNEL_AW      (1'b1)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .valid_i            (valid_i),
      .addr_i             (addr_i),
      .ready_o            (ready_o),
      .valid_o            (valid_o),
      .ready_i            (ready_i),
      .start_addr_i       (start_addr_i),
      .end_addr_i         (end_addr_i),
      .enable_region_i    (enable_region_i),
      .connectivity_map_i (connectivity_map_i),
      .default_en_i       (default_en_i),
      .default_port_i     (default_port_i),
      .trans_done_i       (trans_done_i),
      .target_o           (target_o),
      .outstanding_o      (outstanding_o),
      .error_req_o        (error_req_o),
      .error_gnt_i        (error_gnt_i),
      .sample_info_o      (sample_info_o)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_region(input int r, input int p, input logic [AW-1:0] s, input logic [AW-1:0] e);
      start_addr_i[(r*NP+p)*AW +: AW] = s;
      end_addr_i[(r*NP+p)*AW +: AW]   = e;
      enable_region_i[r*NP+p]         = 1'b1;
   endtask

   task automatic pulse_done();
      trans_done_i = 1'b1;
      tick();
      trans_done_i = 1'b0;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      rst_n = 1'b0;
      valid_i = 1'b0;
      addr_i = '0;
      ready_i = '0;
      start_addr_i = '0;
      end_addr_i = '0;
      enable_region_i = '0;
      connectivity_map_i = '1;
      default_en_i = 1'b0;
      default_port_i = '0;
      trans_done_i = 1'b0;
      error_gnt_i = 1'b0;

      set_region(0, 2, 32'h1000, 32'h1FFF);
      set_region(1, 1, 32'h2000, 32'h2FFF);
      set_region(0, 3, 32'h2000, 32'h20FF);
      set_region(2, 0, 32'h3000, 32'h3FFF);
      set_region(3, 4, 32'h4000, 32'h4FFF);

      // Reset state
      tick();
      check_eq("rst_valid_o", 64'(valid_o), 64'h0);
      check_eq("rst_ready_o", 64'(ready_o), 64'h0);
      check_eq("rst_cnt", 64'(outstanding_o), 64'h0);
      check_eq("rst_target", 64'(target_o), 64'h0);
      check_eq("rst_err_req", 64'(error_req_o), 64'h0);
      check_eq("rst_sample", 64'(sample_info_o), 64'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Simple hit to port 2, zero-cycle latency
      valid_i = 1'b1; addr_i = 32'h1800; ready_i = 8'h04;
      settle();
      check_eq("hit_valid_o", 64'(valid_o), 64'h04);
      check_eq("hit_ready_o", 64'(ready_o), 64'h1);
      check_eq("hit_sample_aw", 64'(sample_info_o), 64'h1);
      tick();
      valid_i = 1'b0; ready_i = '0;
      settle();
      check_eq("hit_cnt", 64'(outstanding_o), 64'h1);
      check_eq("hit_target", 64'(target_o), 64'h2);
      pulse_done();
      check_eq("hit_drain_cnt", 64'(outstanding_o), 64'h0);

      // Overlap: ports 1 and 3 both match, lowest wins; hold through map change
      valid_i = 1'b1; addr_i = 32'h2000; ready_i = '0;
      settle();
      check_eq("ovl_valid_o", 64'(valid_o), 64'h02);
      check_eq("ovl_ready_o", 64'(ready_o), 64'h0);
      tick();
      connectivity_map_i = 8'hFD;
      for (int i = 0; i < 3; i++) begin
         settle();
         check_eq("hold_valid_o", 64'(valid_o), 64'h02);
         tick();
      end
      ready_i = 8'h02;
      settle();
      check_eq("hold_ready_o", 64'(ready_o), 64'h1);
      tick();
      valid_i = 1'b0; ready_i = '0; connectivity_map_i = '1;
      settle();
      check_eq("hold_cnt", 64'(outstanding_o), 64'h1);
      check_eq("hold_target", 64'(target_o), 64'h1);
      check_eq("hold_release", 64'(valid_o), 64'h0);
      pulse_done();

      // Depth limit: two issues to port 0, third stalls until a completion
      valid_i = 1'b1; addr_i = 32'h3000; ready_i = 8'h01;
      tick();
      tick();
      settle();
      check_eq("lim_cnt2", 64'(outstanding_o), 64'h2);
      check_eq("lim_stall_valid", 64'(valid_o), 64'h0);
      check_eq("lim_stall_ready", 64'(ready_o), 64'h0);
      tick();
      check_eq("lim_stall_ready2", 64'(ready_o), 64'h0);
      trans_done_i = 1'b1;
      tick();
      trans_done_i = 1'b0;
      settle();
      check_eq("lim_cnt1", 64'(outstanding_o), 64'h1);
      check_eq("lim_issue_valid", 64'(valid_o), 64'h01);
      check_eq("lim_issue_ready", 64'(ready_o), 64'h1);
      tick();
      valid_i = 1'b0;
      settle();
      check_eq("lim_cnt2b", 64'(outstanding_o), 64'h2);
      pulse_done();
      check_eq("lim_cnt1b", 64'(outstanding_o), 64'h1);

      // Handshake and completion in the same cycle at cnt = 1
      valid_i = 1'b1; trans_done_i = 1'b1;
      tick();
      valid_i = 1'b0; trans_done_i = 1'b0;
      settle();
      check_eq("sim_cnt", 64'(outstanding_o), 64'h1);
      pulse_done();
      check_eq("sim_drain", 64'(outstanding_o), 64'h0);

      // Target lock: outstanding to port 0 blocks port 4
      valid_i = 1'b1; addr_i = 32'h3000; ready_i = 8'h01;
      tick();
      addr_i = 32'h4000; ready_i = 8'h10;
      settle();
      check_eq("lock_stall_valid", 64'(valid_o), 64'h0);
      check_eq("lock_stall_ready", 64'(ready_o), 64'h0);
      tick();
      check_eq("lock_stall_valid2", 64'(valid_o), 64'h0);
      trans_done_i = 1'b1;
      tick();
      trans_done_i = 1'b0;
      settle();
      check_eq("lock_issue_valid", 64'(valid_o), 64'h10);
      check_eq("lock_issue_ready", 64'(ready_o), 64'h1);
      tick();
      tick();
      valid_i = 1'b0; ready_i = '0;
      settle();
      check_eq("lock_target", 64'(target_o), 64'h4);
      check_eq("lock_cnt", 64'(outstanding_o), 64'h2);

      // Unmapped address, no default: absorbed, drained, then error request
      valid_i = 1'b1; addr_i = 32'hF000;
      settle();
      check_eq("err_ready_o", 64'(ready_o), 64'h1);
      check_eq("err_sample", 64'(sample_info_o), 64'h1);
      check_eq("err_valid_o", 64'(valid_o), 64'h0);
      tick();
      valid_i = 1'b0;
      settle();
      check_eq("drain_ready_o", 64'(ready_o), 64'h0);
      check_eq("drain_sample", 64'(sample_info_o), 64'h0);
      check_eq("drain_req0", 64'(error_req_o), 64'h0);
      pulse_done();
      check_eq("drain_req1", 64'(error_req_o), 64'h0);
      pulse_done();
      check_eq("drain_req2", 64'(error_req_o), 64'h0);
      tick();
      check_eq("err_req_up", 64'(error_req_o), 64'h1);
      tick();
      check_eq("err_req_held", 64'(error_req_o), 64'h1);
      error_gnt_i = 1'b1;
      settle();
      check_eq("err_req_gnt", 64'(error_req_o), 64'h1);
      tick();
      error_gnt_i = 1'b0;
      settle();
      check_eq("err_req_done", 64'(error_req_o), 64'h0);
      check_eq("err_cnt", 64'(outstanding_o), 64'h0);

      // Same address with default port 5
      default_en_i = 1'b1; default_port_i = 3'd5;
      valid_i = 1'b1; addr_i = 32'hF000; ready_i = 8'h20;
      settle();
      check_eq("dflt_valid_o", 64'(valid_o), 64'h20);
      check_eq("dflt_ready_o", 64'(ready_o), 64'h1);
      tick();
      ready_i = '0;
      settle();
      check_eq("dflt_cnt", 64'(outstanding_o), 64'h1);
      check_eq("dflt_target", 64'(target_o), 64'h5);
      tick();
      settle();
      check_eq("dflt_hold", 64'(valid_o), 64'h20);

      // Async reset in HOLD clears everything at once
      rst_n = 1'b0;
      settle();
      check_eq("arst_valid_o", 64'(valid_o), 64'h0);
      check_eq("arst_ready_o", 64'(ready_o), 64'h0);
      check_eq("arst_cnt", 64'(outstanding_o), 64'h0);
      check_eq("arst_target", 64'(target_o), 64'h0);
      valid_i = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
